// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter letting NREQ requesters share one SPI master, one transaction at a time.
// Ports: clk_i/rst_ni clock and async active-low reset; req_val_i/req_rdy_o/req_msg_i/req_len_i request side;
// resp_val_o/resp_rdy_i/resp_msg_o response side; spi_send_*, spi_pkt_size_o, spi_cs_addr_o, spi_recv_* SPI master side.
module spi_master_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 34,
  parameter int LBITS = $clog2(NBITS+1),
  parameter int ABITS = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_val_i,
  output logic [NREQ-1:0]       req_rdy_o,
  input  logic [NREQ*NBITS-1:0] req_msg_i,
  input  logic [NREQ*LBITS-1:0] req_len_i,
  output logic [NREQ-1:0]       resp_val_o,
  input  logic [NREQ-1:0]       resp_rdy_i,
  output logic [NBITS-1:0]      resp_msg_o,
  output logic                  spi_send_val_o,
  input  logic                  spi_send_rdy_i,
  output logic [NBITS-1:0]      spi_send_msg_o,
  output logic [LBITS-1:0]      spi_pkt_size_o,
  output logic [ABITS-1:0]      spi_cs_addr_o,
  input  logic                  spi_recv_val_i,
  output logic                  spi_recv_rdy_o,
  input  logic [NBITS-1:0]      spi_recv_msg_i
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RECV, DELIVER} state_e;
  state_e state_q, state_d;
  logic [ABITS-1:0] ptr_q, ptr_d, grant_q, grant_d, pick;
  logic [NBITS-1:0] msg_q, msg_d, resp_q, resp_d;
  logic [LBITS-1:0] len_q, len_d, pick_len, clamp_len;
  logic found;
  function automatic logic [ABITS-1:0] wrap(input int v);
    return ABITS'(v % NREQ);
  endfunction
  // Walk downward so the nearest valid requester at or after ptr wins.
  always_comb begin
    found = 1'b0;
    pick = ptr_q;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_val_i[wrap(int'(ptr_q)+k)]) begin
        found = 1'b1;
        pick = wrap(int'(ptr_q)+k);
      end
    end
    pick_len = req_len_i[int'(pick)*LBITS +: LBITS];
    clamp_len = (pick_len > LBITS'(NBITS)) ? LBITS'(NBITS) : pick_len;
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    msg_d = msg_q;
    len_d = len_q;
    resp_d = resp_q;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        msg_d = req_msg_i[int'(pick)*NBITS +: NBITS];
        len_d = clamp_len;
        resp_d = '0;
        state_d = (clamp_len == '0) ? DELIVER : SEND;
      end
      SEND: state_d = spi_send_rdy_i ? WAIT_RECV : SEND;
      WAIT_RECV: if (spi_recv_val_i) begin
        resp_d = spi_recv_msg_i;
        state_d = DELIVER;
      end
      default: if (resp_rdy_i[grant_q]) begin
        ptr_d = wrap(int'(grant_q)+1);
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      msg_q <= '0;
      len_q <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      msg_q <= msg_d;
      len_q <= len_d;
      resp_q <= resp_d;
    end
  end
  // Handshake outputs are gated by reset so they drop in the same cycle reset asserts.
  assign req_rdy_o = (rst_ni && state_q == IDLE && found) ? NREQ'(1) << pick : '0;
  assign resp_val_o = (rst_ni && state_q == DELIVER) ? NREQ'(1) << grant_q : '0;
  assign spi_send_val_o = rst_ni && state_q == SEND;
  assign spi_recv_rdy_o = rst_ni && state_q == WAIT_RECV;
  assign spi_send_msg_o = msg_q;
  assign spi_pkt_size_o = len_q;
  assign spi_cs_addr_o = grant_q;
  assign resp_msg_o = resp_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: directed self-checking bench for spi_master_arbiter with NREQ=4, NBITS=34.
module tb_spi_master_arbiter;
  localparam int N = 4, NB = 34, LB = 6, AB = 2;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [N-1:0] req_val = '0, req_rdy, resp_val, resp_rdy = '0;
  logic [N*NB-1:0] req_msg = '0;
  logic [N*LB-1:0] req_len = '0;
  logic [NB-1:0] resp_msg, send_msg, recv_msg = '0;
  logic send_val, send_rdy = 1'b0, recv_val = 1'b0, recv_rdy;
  logic [LB-1:0] pkt_size;
  logic [AB-1:0] cs_addr;
  int total = 0, fails = 0;
  logic [N-1:0] order [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  always #5 clk = ~clk;
  spi_master_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_val_i(req_val), .req_rdy_o(req_rdy), .req_msg_i(req_msg), .req_len_i(req_len),
    .resp_val_o(resp_val), .resp_rdy_i(resp_rdy), .resp_msg_o(resp_msg),
    .spi_send_val_o(send_val), .spi_send_rdy_i(send_rdy), .spi_send_msg_o(send_msg),
    .spi_pkt_size_o(pkt_size), .spi_cs_addr_o(cs_addr),
    .spi_recv_val_i(recv_val), .spi_recv_rdy_o(recv_rdy), .spi_recv_msg_i(recv_msg)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input string tag, input logic [N-1:0] g, input logic [NB-1:0] rmsg);
    check({tag, "_rdy"}, req_rdy, g);
    tick;
    check({tag, "_sval"}, send_val, 1);
    send_rdy = 1'b1;
    tick;
    send_rdy = 1'b0;
    check({tag, "_rrdy"}, recv_rdy, 1);
    recv_val = 1'b1;
    recv_msg = rmsg;
    tick;
    recv_val = 1'b0;
    check({tag, "_rval"}, resp_val, g);
    check({tag, "_rmsg"}, resp_msg, rmsg);
    resp_rdy = g;
    tick;
    resp_rdy = '0;
  endtask
  initial begin
    req_val = 4'b1111;
    #2;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_send_val", send_val, 0);
    check("rst_recv_rdy", recv_rdy, 0);
    check("rst_cs_addr", cs_addr, 0);
    req_val = '0;
    tick;
    tick;
    rst_ni = 1'b1;
    req_val = 4'b0100;
    req_msg[2*NB +: NB] = 34'h2_A5A5_A5A5;
    req_len[2*LB +: LB] = 6'd34;
    #1;
    check("b1_rdy", req_rdy, 4'b0100);
    tick;
    req_val = '0;
    check("b1_sval", send_val, 1);
    check("b1_addr", cs_addr, 2);
    check("b1_size", pkt_size, 34);
    check("b1_smsg", send_msg, 34'h2_A5A5_A5A5);
    check("b1_req_rdy", req_rdy, 0);
    send_rdy = 1'b1;
    tick;
    send_rdy = 1'b0;
    check("b1_rrdy", recv_rdy, 1);
    check("b1_sval_lo", send_val, 0);
    recv_val = 1'b1;
    recv_msg = 34'h1234;
    tick;
    recv_val = 1'b0;
    check("b1_rval", resp_val, 4'b0100);
    check("b1_rmsg", resp_msg, 34'h1234);
    resp_rdy = 4'b0100;
    tick;
    resp_rdy = '0;
    check("b1_idle_rval", resp_val, 0);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_msg[i*NB +: NB] = NB'(34'h1_0000_0000 + i);
      req_len[i*LB +: LB] = 6'd34;
    end
    req_val = 4'b1111;
    #1;
    for (int t = 0; t < 8; t++) txn($sformatf("rr%0d", t), order[t], NB'(34'h3_0000_0000 + t));
    req_val = 4'b0010;
    req_msg[1*NB +: NB] = 34'h0_DEAD_BEEF;
    req_len[1*LB +: LB] = 6'd10;
    #1;
    check("st_rdy", req_rdy, 4'b0010);
    tick;
    req_val = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("st%0d_sval", c), send_val, 1);
      check($sformatf("st%0d_smsg", c), send_msg, 34'h0_DEAD_BEEF);
      check($sformatf("st%0d_size", c), pkt_size, 10);
      check($sformatf("st%0d_addr", c), cs_addr, 1);
      check($sformatf("st%0d_req_rdy", c), req_rdy, 0);
      tick;
    end
    send_rdy = 1'b1;
    tick;
    send_rdy = 1'b0;
    recv_val = 1'b1;
    recv_msg = 34'h55;
    tick;
    recv_val = 1'b0;
    check("dl_rval", resp_val, 4'b0010);
    resp_rdy = 4'b1000;
    tick;
    check("dl_ignore_rval", resp_val, 4'b0010);
    resp_rdy = 4'b0010;
    tick;
    resp_rdy = '0;
    check("dl_ptr2_rdy", req_rdy, 4'b0100);
    req_val = 4'b0010;
    req_len[1*LB +: LB] = 6'd0;
    #1;
    check("z_rdy", req_rdy, 4'b0010);
    tick;
    req_val = '0;
    check("z_sval", send_val, 0);
    check("z_rval", resp_val, 4'b0010);
    check("z_rmsg", resp_msg, 0);
    resp_rdy = 4'b0010;
    tick;
    resp_rdy = '0;
    req_val = 4'b0010;
    req_len[1*LB +: LB] = 6'd40;
    tick;
    req_val = '0;
    check("cl_size", pkt_size, 34);
    send_rdy = 1'b1;
    tick;
    send_rdy = 1'b0;
    check("rw_rrdy", recv_rdy, 1);
    req_val = 4'b1001;
    req_len[0] = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("rw_rrdy_lo", recv_rdy, 0);
    check("rw_sval", send_val, 0);
    check("rw_rval", resp_val, 0);
    check("rw_req_rdy", req_rdy, 0);
    #3;
    rst_ni = 1'b1;
    #1;
    check("rw_grant0", req_rdy, 4'b0001);
    tick;
    check("rw_sval_hi", send_val, 1);
    check("rw_addr", cs_addr, 0);
    check("rw_no_resp", resp_val, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
